sprite_compositor: RTL and testbench

- Parametrised pixel compositor for the VGA output path; the successor to the fixed three-sprite colour mux.
- Merges N_LAYERS sprite layers into one 12-bit RGB pixel stream. Selection is by fixed priority, with per-layer colour and enable and a programmable background.
- Delays hsync/vsync to match the pixel pipeline.
- Detects pixel-exact overlap between the player layer and every other layer, and reports it live and per frame for the game-state logic.

---
 rtl/vga_pkg.sv | 29 ++
 rtl/sprite_compositor_priority_select.sv | 29 ++
 rtl/sprite_compositor.sv | 127 ++++++++++++
 tb/tb_sprite_compositor.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA definitions: colour format, stock sprite colours and layer slots
// used by the sprite compositor and the game-state logic.
package vga_pkg;

  localparam int COLOR_W = 4;
  localparam int PIX_W   = 3 * COLOR_W;

  typedef struct packed {
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } rgb_t;

  localparam rgb_t COLOR_BLACK  = 12'h000;
  localparam rgb_t COLOR_WHITE  = 12'hFFF;
  localparam rgb_t COLOR_PLAYER = 12'hE10;
  localparam rgb_t COLOR_BULLET = 12'hED0;
  localparam rgb_t COLOR_BORDER = 12'hFFF;

  localparam int LAYER_BORDER = 0;
  localparam int LAYER_PLAYER = 1;
  localparam int LAYER_BULLET = 2;

  // Flattens a colour into the {R,G,B} bus layout used on the layer ports.
  function automatic logic [PIX_W-1:0] rgb_pack(input rgb_t c);
    return {c.r, c.g, c.b};
  endfunction

endpackage

// File: rtl/sprite_compositor_priority_select.sv
// Combinational fixed-priority colour select: the lowest-index active layer
// wins, falling back to the background colour when no layer is active.
module priority_select #(
  parameter int N_LAYERS = 4,
  parameter int PIX_W    = 12
) (
  input  logic [N_LAYERS-1:0]       sel_on,
  input  logic [N_LAYERS*PIX_W-1:0] layer_rgb,
  input  logic [PIX_W-1:0]          bg_rgb,
  output logic [PIX_W-1:0]          rgb
);

  logic [N_LAYERS-1:0] onehot_s;
  logic [PIX_W-1:0]    mux_s;

  // x & -x isolates the lowest set bit, i.e. the highest-priority layer.
  assign onehot_s = sel_on & (~sel_on + {{(N_LAYERS-1){1'b0}}, 1'b1});

  // AND-OR mux over the one-hot select.
  always_comb begin
    mux_s = {PIX_W{1'b0}};
    for (int i = 0; i < N_LAYERS; i++) begin
      mux_s = mux_s | ({PIX_W{onehot_s[i]}} & layer_rgb[i*PIX_W +: PIX_W]);
    end
  end

  assign rgb = (|sel_on) ? mux_s : bg_rgb;

endmodule

// File: rtl/sprite_compositor.sv
// N-layer sprite compositor: two-stage pixel pipeline with matched sync delay
// and per-frame player collision capture.
module sprite_compositor #(
  parameter int   N_LAYERS   = 4,
  parameter int   PLAYER_IDX = vga_pkg::LAYER_PLAYER,
  parameter int   COLOR_W    = vga_pkg::COLOR_W,
  parameter logic SYNC_IDLE  = 1'b1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            p_tick,
  input  logic                            video_on,
  input  logic                            hsync_in,
  input  logic                            vsync_in,
  input  logic [N_LAYERS-1:0]             layer_on,
  input  logic [N_LAYERS*3*COLOR_W-1:0]   layer_rgb,
  input  logic [N_LAYERS-1:0]             layer_en,
  input  logic [3*COLOR_W-1:0]            bg_rgb,
  input  logic                            frame_end,
  output logic [COLOR_W-1:0]              vga_r,
  output logic [COLOR_W-1:0]              vga_g,
  output logic [COLOR_W-1:0]              vga_b,
  output logic                            hsync_out,
  output logic                            vsync_out,
  output logic [N_LAYERS-1:0]             hit_live,
  output logic [N_LAYERS-1:0]             hit_frame,
  output logic                            hit_pulse
);

  localparam int PIX_W = 3 * COLOR_W;

  logic [N_LAYERS-1:0] eff_on_s;
  logic [N_LAYERS-1:0] hitvec_s;
  logic [N_LAYERS-1:0] hit_acc_s;
  logic [PIX_W-1:0]    sel_rgb_s;
  logic [PIX_W-1:0]    s1_rgb_s;

  logic [PIX_W-1:0]    s1_rgb_r;
  logic                s1_vid_r;
  logic                s1_hs_r;
  logic                s1_vs_r;
  logic [PIX_W-1:0]    out_rgb_r;
  logic                hs_out_r;
  logic                vs_out_r;
  logic [N_LAYERS-1:0] hit_live_r;
  logic [N_LAYERS-1:0] hit_frame_r;
  logic                hit_pulse_r;

  assign eff_on_s = layer_on & layer_en;

  priority_select #(
    .N_LAYERS (N_LAYERS),
    .PIX_W    (PIX_W)
  ) u_sel (
    .sel_on    (eff_on_s),
    .layer_rgb (layer_rgb),
    .bg_rgb    (bg_rgb),
    .rgb       (sel_rgb_s)
  );

  assign s1_rgb_s = video_on ? sel_rgb_s : {PIX_W{1'b0}};

  // Player overlap vector; the player never collides with itself.
  always_comb begin
    hitvec_s = {N_LAYERS{1'b0}};
    for (int i = 0; i < N_LAYERS; i++) begin
      if (i != PLAYER_IDX) begin
        hitvec_s[i] = video_on & eff_on_s[PLAYER_IDX] & eff_on_s[i];
      end else begin
        hitvec_s[i] = 1'b0;
      end
    end
  end

  assign hit_acc_s = hit_live_r | hitvec_s;

  // Two-stage pixel and sync pipeline, advancing only on pixel ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_rgb_r  <= {PIX_W{1'b0}};
      s1_vid_r  <= 1'b0;
      s1_hs_r   <= 1'b0;
      s1_vs_r   <= 1'b0;
      out_rgb_r <= {PIX_W{1'b0}};
      hs_out_r  <= SYNC_IDLE;
      vs_out_r  <= SYNC_IDLE;
    end else if (p_tick) begin
      s1_rgb_r  <= s1_rgb_s;
      s1_vid_r  <= video_on;
      s1_hs_r   <= hsync_in;
      s1_vs_r   <= vsync_in;
      out_rgb_r <= s1_vid_r ? s1_rgb_r : {PIX_W{1'b0}};
      hs_out_r  <= s1_hs_r;
      vs_out_r  <= s1_vs_r;
    end
  end

  // Collision accumulation; a hit on the closing pixel still counts for its frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_live_r  <= {N_LAYERS{1'b0}};
      hit_frame_r <= {N_LAYERS{1'b0}};
      hit_pulse_r <= 1'b0;
    end else begin
      hit_pulse_r <= 1'b0;
      if (p_tick) begin
        if (frame_end) begin
          hit_frame_r <= hit_acc_s;
          hit_live_r  <= {N_LAYERS{1'b0}};
          hit_pulse_r <= |hit_acc_s;
        end else begin
          hit_live_r  <= hit_acc_s;
        end
      end
    end
  end

  assign vga_r     = out_rgb_r[PIX_W-1 -: COLOR_W];
  assign vga_g     = out_rgb_r[2*COLOR_W-1 -: COLOR_W];
  assign vga_b     = out_rgb_r[COLOR_W-1:0];
  assign hsync_out = hs_out_r;
  assign vsync_out = vs_out_r;
  assign hit_live  = hit_live_r;
  assign hit_frame = hit_frame_r;
  assign hit_pulse = hit_pulse_r;

endmodule

// File: tb/tb_sprite_compositor.sv
// Bench for sprite_compositor: directed scenarios with literal expectations,
// then random traffic, all compared every cycle against a behavioural model.
module tb_sprite_compositor;

  localparam int N  = 4;
  localparam int PW = 12;
  localparam int P  = 1;

  logic          clk;
  logic          rst_n;
  logic          p_tick;
  logic          video_on;
  logic          hsync_in;
  logic          vsync_in;
  logic [N-1:0]  layer_on;
  logic [N*PW-1:0] layer_rgb;
  logic [N-1:0]  layer_en;
  logic [PW-1:0] bg_rgb;
  logic          frame_end;
  logic [3:0]    vga_r;
  logic [3:0]    vga_g;
  logic [3:0]    vga_b;
  logic          hsync_out;
  logic          vsync_out;
  logic [N-1:0]  hit_live;
  logic [N-1:0]  hit_frame;
  logic          hit_pulse;

  int n_checks = 0;
  int n_pass   = 0;

  sprite_compositor #(
    .N_LAYERS   (4),
    .PLAYER_IDX (1),
    .COLOR_W    (4),
    .SYNC_IDLE  (1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .p_tick    (p_tick),
    .video_on  (video_on),
    .hsync_in  (hsync_in),
    .vsync_in  (vsync_in),
    .layer_on  (layer_on),
    .layer_rgb (layer_rgb),
    .layer_en  (layer_en),
    .bg_rgb    (bg_rgb),
    .frame_end (frame_end),
    .vga_r     (vga_r),
    .vga_g     (vga_g),
    .vga_b     (vga_b),
    .hsync_out (hsync_out),
    .vsync_out (vsync_out),
    .hit_live  (hit_live),
    .hit_frame (hit_frame),
    .hit_pulse (hit_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference: scan layers from highest priority, first enabled hit wins.
  function automatic logic [PW-1:0] ref_pixel(input logic vid, input logic [N-1:0] on,
                                               input logic [N-1:0] en, input logic [N*PW-1:0] rgb,
                                               input logic [PW-1:0] bg);
    logic [PW-1:0] p;
    bit found;
    p = bg;
    found = 0;
    for (int i = 0; i < N; i++) begin
      if (!found && on[i] && en[i]) begin
        p = rgb[i*PW +: PW];
        found = 1;
      end
    end
    if (!vid) p = 12'h000;
    return p;
  endfunction

  function automatic logic [N-1:0] ref_hits(input logic vid, input logic [N-1:0] on,
                                            input logic [N-1:0] en);
    logic [N-1:0] h;
    h = 4'b0000;
    if (vid && on[P] && en[P]) begin
      for (int i = 0; i < N; i++) if (i != P) h[i] = on[i] & en[i];
    end
    return h;
  endfunction

  // Model state: a two-slot delay line for pixels/syncs plus frame hit sets.
  logic [PW-1:0] m_s1_rgb, m_out_rgb;
  logic          m_s1_hs, m_s1_vs, m_hs, m_vs;
  logic [N-1:0]  m_live, m_frame;
  logic          m_pulse;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1_rgb  <= 12'h000;
      m_s1_hs   <= 1'b0;
      m_s1_vs   <= 1'b0;
      m_out_rgb <= 12'h000;
      m_hs      <= 1'b1;
      m_vs      <= 1'b1;
      m_live    <= 4'b0000;
      m_frame   <= 4'b0000;
      m_pulse   <= 1'b0;
    end else begin
      m_pulse <= 1'b0;
      if (p_tick) begin
        m_s1_rgb  <= ref_pixel(video_on, layer_on, layer_en, layer_rgb, bg_rgb);
        m_s1_hs   <= hsync_in;
        m_s1_vs   <= vsync_in;
        m_out_rgb <= m_s1_rgb;
        m_hs      <= m_s1_hs;
        m_vs      <= m_s1_vs;
        if (frame_end) begin
          m_frame <= m_live | ref_hits(video_on, layer_on, layer_en);
          m_live  <= 4'b0000;
          m_pulse <= |(m_live | ref_hits(video_on, layer_on, layer_en));
        end else begin
          m_live  <= m_live | ref_hits(video_on, layer_on, layer_en);
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("model_pixel", 32'({vga_r, vga_g, vga_b}), 32'(m_out_rgb));
    chk("model_sync", 32'({hsync_out, vsync_out}), 32'({m_hs, m_vs}));
    chk("model_hit_live", 32'(hit_live), 32'(m_live));
    chk("model_hit_frame", 32'(hit_frame), 32'(m_frame));
    chk("model_hit_pulse", 32'(hit_pulse), 32'(m_pulse));
  end

  task automatic step(input logic pt, input logic fe);
    @(negedge clk);
    #1;
    p_tick    = pt;
    frame_end = fe;
  endtask

  // One qualified pixel followed by three idle clocks.
  task automatic qcycle(input logic fe);
    step(1'b1, fe);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
  endtask

  function automatic logic [PW-1:0] pix();
    return {vga_r, vga_g, vga_b};
  endfunction

  initial begin
    rst_n     = 1'b0;
    p_tick    = 1'b0;
    frame_end = 1'b0;
    video_on  = 1'b0;
    hsync_in  = 1'b1;
    vsync_in  = 1'b1;
    layer_on  = 4'b0000;
    layer_en  = 4'b1111;
    layer_rgb = {12'h00F, 12'hED0, 12'hE10, 12'hFFF};
    bg_rgb    = 12'h123;
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    chk("reset_pixel", 32'(pix()), 32'h000);
    chk("reset_sync", 32'({hsync_out, vsync_out}), 32'h3);
    chk("reset_hits", 32'({hit_live, hit_frame, hit_pulse}), 32'h000);
    step(1'b0, 1'b0);
    rst_n = 1'b1;

    // Priority: layers 1 and 2 on, layer 1 wins; sync delayed two pixels.
    video_on = 1'b1;
    layer_on = 4'b0110;
    hsync_in = 1'b0;
    qcycle(1'b0);
    chk("prio_q1_pixel", 32'(pix()), 32'h000);
    chk("prio_q1_sync", 32'({hsync_out, vsync_out}), 32'h0);
    chk("prio_hit_live", 32'(hit_live), 32'h4);
    hsync_in = 1'b1;
    qcycle(1'b0);
    chk("prio_q2_pixel", 32'(pix()), 32'hE10);
    chk("prio_q2_sync", 32'({hsync_out, vsync_out}), 32'h1);
    layer_on = 4'b0000;
    qcycle(1'b0);
    chk("prio_q3_sync", 32'({hsync_out, vsync_out}), 32'h3);

    // frame_end without p_tick is ignored.
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    chk("fe_noptick_live", 32'(hit_live), 32'h4);
    chk("fe_noptick_pulse", 32'({hit_frame, hit_pulse}), 32'h0);

    // Frame close captures the accumulated hit.
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    chk("fe_pulse", 32'(hit_pulse), 32'h1);
    chk("fe_frame", 32'(hit_frame), 32'h4);
    chk("fe_live", 32'(hit_live), 32'h0);
    step(1'b0, 1'b0);
    chk("fe_pulse_one_clk", 32'(hit_pulse), 32'h0);

    // Disabled player layer shows background; blanking forces black.
    layer_on = 4'b0010;
    layer_en = 4'b1101;
    qcycle(1'b0);
    qcycle(1'b0);
    chk("bg_pixel", 32'(pix()), 32'h123);
    video_on = 1'b0;
    qcycle(1'b0);
    qcycle(1'b0);
    chk("blank_pixel", 32'(pix()), 32'h000);

    // Overlap on the same pixel as frame_end belongs to the closing frame.
    video_on = 1'b1;
    layer_en = 4'b1111;
    layer_on = 4'b0110;
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    chk("same_cycle_frame", 32'(hit_frame), 32'h4);
    chk("same_cycle_live", 32'(hit_live), 32'h0);
    chk("same_cycle_pulse", 32'(hit_pulse), 32'h1);
    layer_on = 4'b0000;
    qcycle(1'b0);
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    chk("clean_frame", 32'({hit_frame, hit_pulse}), 32'h0);

    // Blanked or disabled layers never collide.
    layer_on = 4'b1010;
    video_on = 1'b0;
    qcycle(1'b0);
    video_on = 1'b1;
    layer_en = 4'b0111;
    qcycle(1'b0);
    chk("no_hit_live", 32'(hit_live), 32'h0);

    // Async reset mid-frame with a live hit.
    layer_en = 4'b1111;
    qcycle(1'b0);
    chk("pre_reset_live", 32'(hit_live), 32'h8);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_pixel", 32'(pix()), 32'h000);
    chk("async_sync", 32'({hsync_out, vsync_out}), 32'h3);
    chk("async_hits", 32'({hit_live, hit_frame, hit_pulse}), 32'h000);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    rst_n = 1'b1;
    layer_on = 4'b0100;
    qcycle(1'b0);
    chk("post_reset_q1", 32'(pix()), 32'h000);
    qcycle(1'b0);
    chk("post_reset_q2", 32'(pix()), 32'hED0);

    // Random traffic, inputs changing on every clock.
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      #1;
      p_tick    = ($urandom_range(0, 2) == 0);
      frame_end = ($urandom_range(0, 15) == 0);
      video_on  = ($urandom_range(0, 7) != 0);
      layer_on  = 4'($urandom);
      layer_en  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b1111;
      layer_rgb = 48'({$urandom, $urandom});
      bg_rgb    = 12'($urandom);
      if ($urandom_range(0, 9) == 0) hsync_in = ~hsync_in;
      if ($urandom_range(0, 29) == 0) vsync_in = ~vsync_in;
    end

    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
